// File: rtl/fib_uart_tx.sv
// Buffers Fibonacci terms from a one-cycle strobe in a small FIFO and
// transmits them LSB-first as 8N1 UART frames, reporting level and lost terms.
module fib_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              txd,
  output logic              busy,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow,
  output logic [7:0]        drop_count
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]   LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_reg, state_next;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]     level_reg, level_next;
  logic [BAUD_W-1:0]   baud_reg, baud_next;
  logic [2:0]          bit_reg, bit_next;
  logic [7:0]          shift_reg, shift_next;
  logic                txd_reg, txd_next;
  logic                overflow_reg;
  logic [7:0]          drop_reg;
  logic                pop, push, drop, baud_done;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the term.
  assign push      = in_valid && ((level_reg != LEVEL_FULL) || pop);
  assign drop      = in_valid && (level_reg == LEVEL_FULL) && !pop;
  assign baud_done = (baud_reg == BAUD_LAST);

  always_comb begin
    level_next = level_reg;
    if (push && !pop)
      level_next = level_reg + (ADDR_W + 1)'(1);
    else if (pop && !push)
      level_next = level_reg - (ADDR_W + 1)'(1);
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg + BAUD_W'(1);
    bit_next   = bit_reg;
    shift_next = shift_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        baud_next = '0;
        if (level_reg != '0) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next  = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7)
            state_next = STOP;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_next  = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // txd is registered from the next-state view so it lines up with the state.
    txd_next = 1'b1;
    if (state_next == START)
      txd_next = 1'b0;
    else if (state_next == DATA)
      txd_next = shift_next[0];
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      baud_reg     <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      txd_reg      <= 1'b1;
      overflow_reg <= 1'b0;
      drop_reg     <= '0;
    end else begin
      state_reg <= state_next;
      level_reg <= level_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      txd_reg   <= txd_next;
      if (pop)
        shift_reg <= mem[rd_ptr_reg];
      else
        shift_reg <= shift_next;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_reg != 8'hFF)
          drop_reg <= drop_reg + 8'd1;
      end
    end
  end

  assign txd        = txd_reg;
  assign busy       = (state_reg != IDLE);
  assign fifo_level = level_reg;
  assign overflow   = overflow_reg;
  assign drop_count = drop_reg;

endmodule

// File: tb/tb_fib_uart_tx.sv
// Directed bench for fib_uart_tx: cycle tables, frame decoding, overflow,
// drop-count saturation, mid-frame reset and a Fibonacci term stream.
module tb_fib_uart_tx;
  localparam int CPB = 4;
  localparam int AW  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          txd, busy, overflow;
  logic [AW:0]   fifo_level;
  logic [7:0]    drop_count;

  fib_uart_tx #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .txd(txd), .busy(busy), .fifo_level(fifo_level),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int applied = 0;
  int miscompares = 0;
  int frame_err = 0;
  logic [7:0] rx_q[$];
  int start_q[$];

  typedef struct {
    int   c;
    logic txd;
    logic busy;
    int   level;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    rx_q.delete();
    start_q.delete();
    frame_err = 0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("frame_count", rx_q.size(), n);
  endtask

  // UART receiver: samples each bit in the middle of its CPB-cycle window.
  initial begin : monitor
    int t;
    logic in_frame;
    logic [7:0] sh;
    in_frame = 1'b0;
    t = 0;
    sh = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        in_frame = 1'b0;
      end else if (!in_frame) begin
        if (txd == 1'b0) begin
          in_frame = 1'b1;
          t = 0;
          start_q.push_back(cyc);
        end
      end else begin
        t++;
        if (t >= 6 && t <= 34 && ((t - 6) % 4) == 0)
          sh[(t - 6) / 4] = txd;
        if (t == 38) begin
          if (txd !== 1'b1) frame_err++;
          rx_q.push_back(sh);
          in_frame = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tv[12];
    int p, lows;
    logic [7:0] x, y, z;
    logic [7:0] exp_q[$];

    tv[0]  = '{0,  1'b1, 1'b0, 0};
    tv[1]  = '{1,  1'b1, 1'b0, 1};
    tv[2]  = '{2,  1'b0, 1'b1, 0};
    tv[3]  = '{5,  1'b0, 1'b1, 0};
    tv[4]  = '{6,  1'b1, 1'b1, 0};
    tv[5]  = '{9,  1'b1, 1'b1, 0};
    tv[6]  = '{10, 1'b0, 1'b1, 0};
    tv[7]  = '{13, 1'b0, 1'b1, 0};
    tv[8]  = '{37, 1'b0, 1'b1, 0};
    tv[9]  = '{38, 1'b1, 1'b1, 0};
    tv[10] = '{41, 1'b1, 1'b1, 0};
    tv[11] = '{42, 1'b1, 1'b0, 0};

    // Reset state and a long idle period.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      check("idle_txd", txd, 1);
      check("idle_busy", busy, 0);
      check("idle_level", fifo_level, 0);
      check("idle_overflow", overflow, 0);
      check("idle_drops", drop_count, 0);
      tick();
    end

    // Single term 0x01 against the cycle table.
    do_reset();
    p = cyc;
    for (int c = 0; c <= 43; c++) begin
      in_valid = (c == 0);
      in_data  = 8'h01;
      for (int j = 0; j < 12; j++) begin
        if (tv[j].c == c) begin
          check($sformatf("single_txd_c%0d", c), txd, tv[j].txd);
          check($sformatf("single_busy_c%0d", c), busy, tv[j].busy);
          check($sformatf("single_level_c%0d", c), fifo_level, tv[j].level);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    wait_frames(1, 50);
    if (rx_q.size() >= 1) begin
      check("single_byte", rx_q[0], 8'h01);
      check("single_start_latency", start_q[0] - p, 2);
    end

    // Back-to-back frames.
    do_reset();
    p = cyc;
    in_valid = 1'b1; in_data = 8'h55; tick();
    in_data = 8'hAA; tick();
    in_valid = 1'b0;
    wait_frames(2, 200);
    if (rx_q.size() >= 2) begin
      check("b2b_byte0", rx_q[0], 8'h55);
      check("b2b_byte1", rx_q[1], 8'hAA);
      check("b2b_first_start", start_q[0] - p, 2);
      check("b2b_gap", start_q[1] - start_q[0], 10 * CPB + 1);
    end

    // Overflow: six consecutive pushes into a depth-4 FIFO.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h41 + 8'(i);
      if (i == 5) check("ovf_level_full", fifo_level, 4);
      tick();
    end
    in_valid = 1'b0;
    check("ovf_flag", overflow, 1);
    check("ovf_drops", drop_count, 1);
    check("ovf_level_after", fifo_level, 4);
    wait_frames(5, 400);
    if (rx_q.size() >= 5)
      for (int i = 0; i < 5; i++)
        check($sformatf("ovf_byte%0d", i), rx_q[i], 8'h41 + 8'(i));
    repeat (3) tick();
    check("ovf_level_drained", fifo_level, 0);
    check("ovf_drops_held", drop_count, 1);
    check("ovf_flag_held", overflow, 1);

    // Drop-count saturation with the FIFO kept full.
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 105; i++) begin
      in_data = 8'(i);
      tick();
    end
    check("sat_drops_98", drop_count, 98);
    for (int i = 0; i < 200; i++) tick();
    in_valid = 1'b0;
    check("sat_drops_255", drop_count, 255);
    check("sat_overflow", overflow, 1);
    in_valid = 1'b1; tick(); in_valid = 1'b0; tick();
    check("sat_drops_hold", drop_count, 255);

    // Reset in the middle of the 0x08 frame, with a second term queued.
    do_reset();
    in_valid = 1'b1; in_data = 8'h08; tick();
    in_data = 8'h33; tick();
    in_valid = 1'b0;
    for (int c = 2; c < 16; c++) tick();
    check("mid_busy_before", busy, 1);
    check("mid_txd_before", txd, 0);
    reset = 1'b1;
    tick();
    check("mid_txd_after", txd, 1);
    check("mid_level_after", fifo_level, 0);
    check("mid_busy_after", busy, 0);
    reset = 1'b0;
    rx_q.delete();
    start_q.delete();
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      if (txd !== 1'b1) lows++;
      tick();
    end
    check("mid_no_frame_after", lows, 0);

    // Fibonacci stream, one term every 11*CPB+1 cycles.
    do_reset();
    x = 8'd1;
    y = 8'd1;
    for (int k = 0; k < 14; k++) begin
      in_valid = 1'b1;
      in_data  = x;
      exp_q.push_back(x);
      tick();
      in_valid = 1'b0;
      repeat (11 * CPB) tick();
      z = x + y;
      x = y;
      y = z;
    end
    wait_frames(14, 200);
    if (rx_q.size() >= 14)
      for (int k = 0; k < 14; k++)
        check($sformatf("fib_term%0d", k), rx_q[k], exp_q[k]);
    check("fib_term13_wrap", exp_q[13], 8'h79);
    check("fib_drops", drop_count, 0);
    check("fib_overflow", overflow, 0);
    check("framing_errors", frame_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
